// File: rtl/chacha_block_ctrl.sv
// ChaCha block controller: sequences the quarter-round datapath through
// alternating column/diagonal rounds, the final feed-forward addition and
// the keystream output handshake.
module chacha_block_ctrl #(
    parameter int DOUBLE_ROUNDS = 10,  // column+diagonal pairs per block, 1..15
    parameter int QR_LATENCY    = 1    // quarter-round datapath latency, 1..8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       ready_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       init_block_o,
    output logic       set_qr_input_o,
    output logic       get_qr_output_o,
    output logic       rotate_block_o,
    output logic       rotate_direction_o,
    output logic       add_input_o,
    output logic       incr_block_ctr_o,
    output logic       valid_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    typedef enum logic [6:0] {
        IDLE      = 7'b0000001,
        WAIT_COL  = 7'b0000010,
        COL       = 7'b0000100,
        WAIT_DIAG = 7'b0001000,
        DIAG      = 7'b0010000,
        FINAL     = 7'b0100000,
        OUT       = 7'b1000000
    } state_t;

    localparam logic [3:0] ROUND_LAST = 4'(DOUBLE_ROUNDS);
    localparam logic [2:0] WAIT_LAST  = 3'(QR_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] round_cnt;
    logic [2:0] wait_cnt;
    logic       wait_last;
    logic       in_wait;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign in_wait   = (state == WAIT_COL) || (state == WAIT_DIAG);
    assign busy_o    = ~ready_o;
    assign round_o   = round_cnt;

    // State register with synchronous reset.
    // NOTE: registers are always assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round counter (completed double rounds) and quarter-round wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            round_cnt <= 4'd0;
            wait_cnt  <= 3'd0;
        end else begin
            if (state == IDLE && start_i) begin
                round_cnt <= 4'd0;
            end else if (state == DIAG) begin
                round_cnt <= round_cnt + 4'd1;
            end

            if (in_wait && !wait_last) begin
                wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end
        end
    end

    // Next-state selection and Moore output decode.
    always_comb begin
        // NOTE: every output and the next state get a default before the case,
        // so no path through this block leaves a signal unassigned (no latch).
        state_next         = state;
        ready_o            = 1'b0;
        init_block_o       = 1'b0;
        set_qr_input_o     = 1'b0;
        get_qr_output_o    = 1'b0;
        rotate_block_o     = 1'b0;
        rotate_direction_o = 1'b0;
        add_input_o        = 1'b0;
        incr_block_ctr_o   = 1'b0;
        valid_o            = 1'b0;
        done_o             = 1'b0;

        case (state)
            IDLE: begin
                ready_o      = 1'b1;
                init_block_o = 1'b1;
                if (start_i) begin
                    state_next = WAIT_COL;
                end
            end
            WAIT_COL: begin
                set_qr_input_o = (wait_cnt == 3'd0);
                if (wait_last) begin
                    state_next = COL;
                end
            end
            COL: begin
                get_qr_output_o    = 1'b1;
                rotate_block_o     = 1'b1;
                rotate_direction_o = 1'b1;
                state_next         = WAIT_DIAG;
            end
            WAIT_DIAG: begin
                set_qr_input_o = (wait_cnt == 3'd0);
                if (wait_last) begin
                    state_next = DIAG;
                end
            end
            DIAG: begin
                get_qr_output_o = 1'b1;
                rotate_block_o  = 1'b1;
                state_next      = (round_cnt + 4'd1 == ROUND_LAST) ? FINAL : WAIT_COL;
            end
            FINAL: begin
                add_input_o      = 1'b1;
                incr_block_ctr_o = 1'b1;
                state_next       = OUT;
            end
            OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    done_o     = ~abort_i;
                    state_next = IDLE;
                end
            end
            default: begin
                // Non-one-hot encodings fall back to idle.
                state_next = IDLE;
            end
        endcase

        // Abort cancels any block in progress; it has no effect when idle.
        if (abort_i && state != IDLE) begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Randomized scoreboard bench for chacha_block_ctrl. A timeline model of a
// block (offset k from start) predicts every output for each cycle.
module tb_chacha_block_ctrl;

    localparam int DR = 4;
    localparam int QL = 3;
    localparam int F  = 2 * DR * (QL + 1) + 1;  // offset of the FINAL cycle
    localparam int NCYCLES = 4000;

    typedef logic [14:0] obs_t;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       ready_o, busy_o, init_block_o, set_qr_input_o, get_qr_output_o;
    logic       rotate_block_o, rotate_direction_o, add_input_o, incr_block_ctr_o;
    logic       valid_o, done_o;
    logic [3:0] round_o;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   run    = 0;

    chacha_block_ctrl #(
        .DOUBLE_ROUNDS(DR),
        .QR_LATENCY   (QL)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .ready_i           (ready_i),
        .ready_o           (ready_o),
        .busy_o            (busy_o),
        .init_block_o      (init_block_o),
        .set_qr_input_o    (set_qr_input_o),
        .get_qr_output_o   (get_qr_output_o),
        .rotate_block_o    (rotate_block_o),
        .rotate_direction_o(rotate_direction_o),
        .add_input_o       (add_input_o),
        .incr_block_ctr_o  (incr_block_ctr_o),
        .valid_o           (valid_o),
        .done_o            (done_o),
        .round_o           (round_o)
    );

    always #5 clk_i = ~clk_i;

    // Completed double rounds visible at block offset j (1 = first cycle after start).
    function automatic int round_at(int j);
        if (j >= F) return DR;
        return (j - 1) / (2 * (QL + 1));
    endfunction

    // Expected outputs for one cycle:
    // {ready,busy,init,set_qr,get_qr,rotate,dir,add,incr,valid,done,round[3:0]}
    function automatic obs_t model_out(bit active, int k, int last_round, bit rdy, bit abt);
        logic [10:0] f = '0;
        int rnd;
        int p;
        int h;
        if (!active) begin
            f[10] = 1'b1;
            f[8]  = 1'b1;
            rnd   = last_round;
        end else begin
            f[9] = 1'b1;
            rnd  = round_at(k);
            if (k < F) begin
                p    = (k - 1) % (QL + 1);   // position inside one half-round
                h    = (k - 1) / (QL + 1);   // half-round index: even = column
                f[7] = (p == 0);
                f[6] = (p == QL);
                f[5] = (p == QL);
                f[4] = (p == QL) && (h % 2 == 0);
            end else if (k == F) begin
                f[3] = 1'b1;
                f[2] = 1'b1;
            end else begin
                f[1] = 1'b1;
                f[0] = rdy && !abt;
            end
        end
        return {f, 4'(rnd)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, req);
        end
    endtask

    // Stimulus and reference model: drive one cycle, push its expectation.
    initial begin
        bit active     = 0;
        int k          = 0;
        int last_round = 0;
        repeat (2) @(posedge clk_i);
        #1;
        run = 1;
        for (int n = 0; n < NCYCLES; n++) begin
            cycle   = n;
            rst_i   = (n == 0) || ($urandom_range(0, 299) == 0);
            start_i = ($urandom_range(0, 3) != 0);
            abort_i = ($urandom_range(0, 79) == 0);
            ready_i = $urandom_range(0, 1);
            exp_q.push_back(model_out(active, k, last_round, ready_i, abort_i));

            if (rst_i) begin
                active     = 0;
                last_round = 0;
            end else if (!active) begin
                if (start_i) begin
                    active     = 1;
                    k          = 1;
                    last_round = 0;
                end
            end else if (abort_i) begin
                active     = 0;
                last_round = round_at(k + 1);
            end else if (k > F && ready_i) begin
                active     = 0;
                last_round = DR;
            end else begin
                k++;
            end
            @(posedge clk_i);
            #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compare the DUT outputs against the oldest expectation each cycle.
    initial begin
        obs_t act;
        obs_t req;
        wait (run);
        forever begin
            @(negedge clk_i);
            act = {ready_o, busy_o, init_block_o, set_qr_input_o, get_qr_output_o,
                   rotate_block_o, rotate_direction_o, add_input_o, incr_block_ctr_o,
                   valid_o, done_o, round_o};
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                req = exp_q.pop_front();
                check("outputs", 32'(act), 32'(req));
            end
        end
    end

endmodule

// File: doc/chacha_block_ctrl.md
CHACHA_BLOCK_CTRL -- requirements
Module: chacha_block_ctrl

Interface
REQ-001 SHALL have parameter DOUBLE_ROUNDS, default 10, number of column+diagonal pairs per block; legal 1..15 (4/6/10 = ChaCha8/12/20).
REQ-002 SHALL have parameter QR_LATENCY, default 1, quarter-round datapath latency in cycles; legal 1..8.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  request new block; accepted only when ready_o=1.
REQ-007 abort_i  in  1  cancel block in progress.
REQ-008 ready_i  in  1  downstream accepts keystream block.
REQ-009 ready_o  out  1  idle, start_i will be accepted.
REQ-010 busy_o  out  1  block in progress (inverse of ready_o).
REQ-011 init_block_o  out  1  load working state from key/nonce/counter.
REQ-012 set_qr_input_o  out  1  launch quarter-round inputs from working state.
REQ-013 get_qr_output_o  out  1  capture quarter-round outputs into working state.
REQ-014 rotate_block_o  out  1  rotate working-state rows.
REQ-015 rotate_direction_o  out  1  1 = column-to-diagonal, 0 = diagonal-to-column.
REQ-016 add_input_o  out  1  add initial state to working state (final feed-forward).
REQ-017 incr_block_ctr_o  out  1  increment 32-bit ChaCha block counter.
REQ-018 valid_o  out  1  keystream block available.
REQ-019 done_o  out  1  single-cycle pulse on output handshake.
REQ-020 round_o  out  4  completed double-round count of current block.

Function
REQ-021 SHALL implement one-hot states IDLE, WAIT_COL, COL, WAIT_DIAG, DIAG, FINAL, OUT; all outputs decoded combinationally from state (Moore), defaulting 0.
REQ-022 IDLE: ready_o=1, init_block_o=1; start_i -> WAIT_COL, round counter cleared to 0, wait counter cleared.
REQ-023 WAIT_COL / WAIT_DIAG: last exactly QR_LATENCY cycles; set_qr_input_o=1 only in first cycle; after last cycle -> COL / DIAG respectively.
REQ-024 COL: get_qr_output_o=1, rotate_block_o=1, rotate_direction_o=1; -> WAIT_DIAG.
REQ-025 DIAG: get_qr_output_o=1, rotate_block_o=1, rotate_direction_o=0; round counter +1; -> FINAL if incremented count = DOUBLE_ROUNDS, else WAIT_COL.
REQ-026 FINAL: add_input_o=1, incr_block_ctr_o=1, exactly one cycle; -> OUT.
REQ-027 OUT: valid_o=1 held until ready_i=1; on valid_o&ready_i done_o=1 same cycle, -> IDLE next cycle; valid_o SHALL NOT drop without handshake or abort.
REQ-028 Latency: cycle 1 = first after start accepted; FINAL at cycle 2*DOUBLE_ROUNDS*(QR_LATENCY+1)+1; valid_o from following cycle.
REQ-029 abort_i in any non-IDLE state -> IDLE next cycle; no done_o, no incr_block_ctr_o afterwards; abort beats ready_i in OUT (no done_o); abort_i ignored in IDLE.
REQ-030 start_i outside IDLE SHALL be ignored, not queued.
REQ-031 round_o SHALL hold count through FINAL/OUT and read 0 after next start; never exceeds DOUBLE_ROUNDS.
REQ-032 Illegal/non-one-hot state SHALL recover to IDLE next cycle.

Reset
REQ-033 rst_i SHALL force IDLE, counters 0 on next edge from any state, overriding start_i/abort_i; after reset ready_o=1, init_block_o=1, all other outputs 0, round_o=0.

Verification
REQ-034 Defaults, start at cycle 0, ready_i=1 -> FINAL cycle 41, valid_o and done_o cycle 42, ready_o cycle 43; round_o=10 at done; 20 get_qr_output_o pulses alternating rotate_direction_o 1,0.
REQ-035 DOUBLE_ROUNDS=4, QR_LATENCY=3 -> set_qr_input_o pulses 3 cycles before each get_qr_output_o; FINAL cycle 33, valid_o cycle 34.
REQ-036 Defaults, ready_i=0 for 5 cycles after valid_o -> valid_o held 6 cycles, single done_o, single incr_block_ctr_o.
REQ-037 abort_i at cycle 15, then at OUT with ready_i=1 -> IDLE next cycle each time, no done_o; start_i during busy ignored.
REQ-038 rst_i asserted mid-DIAG and in OUT -> next cycle ready_o=1, valid_o=0, round_o=0; back-to-back starts yield identical timing.
